// File: rtl/td4_pkg.sv
// td4_pkg: shared constants for the TD4 front panel and core.
// Mode encoding and CPU data-port width.
package td4_pkg;

  localparam int CPU_DW = 4;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_SLOW = 2'b01,
    MODE_FAST = 2'b10,
    MODE_STEP = 2'b11
  } mode_e;

endpackage

// File: rtl/td4_front_panel_if.sv
// td4_front_panel_if: panel-side signal bundle.
// The master drives buttons and mode; the slave returns CPU-facing outputs.
interface td4_front_panel_if;
  import td4_pkg::*;

  logic [CPU_DW-1:0] btn;
  logic              step_n;
  mode_e             mode;
  logic [CPU_DW-1:0] in_data;
  logic              cpu_ce;
  logic              run_led;

  modport master (
    output btn, step_n, mode,
    input  in_data, cpu_ce, run_led
  );

  modport slave (
    input  btn, step_n, mode,
    output in_data, cpu_ce, run_led
  );

endinterface

// File: rtl/td4_debounce.sv
// td4_debounce: 2-flop synchronizer plus stable-level debouncer.
// Accepted level flips only after DB_CYCLES consecutive differing samples.
module td4_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          lvl_q;
  logic          lvl_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // synchronizer, idles at the released (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // count consecutive disagreeing samples; flip on the last one
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // accepted level and debounce counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level_o = lvl_q;

endmodule

// File: rtl/td4_front_panel.sv
// td4_front_panel: button conditioning and CPU clock-enable generation.
// Modes: halt, slow/fast free-run, manual single-step.
module td4_front_panel
  import td4_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int SLOW_DIV  = 50000000,
  parameter int FAST_DIV  = 5000000
) (
  input logic               clk,
  input logic               rst,
  td4_front_panel_if.slave  pnl
);

  localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int RW     = $clog2(MAXDIV);
  localparam logic [RW-1:0] SLOW_LD = RW'(SLOW_DIV - 1);
  localparam logic [RW-1:0] FAST_LD = RW'(FAST_DIV - 1);

  function automatic logic [RW-1:0] reload_val(input mode_e m);
    return (m == MODE_FAST) ? FAST_LD : SLOW_LD;
  endfunction

  logic [CPU_DW-1:0] btn_lvl;
  logic              step_lvl;

  logic [CPU_DW-1:0] in_data_q;
  logic              step_prev_q;
  logic              step_edge_q;
  mode_e             mode_q;
  logic [RW-1:0]     rate_q;
  logic [RW-1:0]     rate_d;
  logic              ce_q;
  logic              ce_d;
  logic              led_q;

  logic              mode_chg;
  logic              step_fall;

  for (genvar i = 0; i < CPU_DW; i++) begin : g_btn
    td4_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (pnl.btn[i]),
      .level_o (btn_lvl[i])
    );
  end

  td4_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_step (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (pnl.step_n),
    .level_o (step_lvl)
  );

  assign mode_chg  = (pnl.mode != mode_q);
  assign step_fall = step_prev_q & ~step_lvl;

  // active-high button data and step press detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data_q   <= '0;
      step_prev_q <= 1'b1;
      step_edge_q <= 1'b0;
    end else begin
      in_data_q   <= ~btn_lvl;
      step_prev_q <= step_lvl;
      step_edge_q <= step_fall;
    end
  end

  // rate counter and pulse select; a mode change reloads and mutes
  always_comb begin
    rate_d = SLOW_LD;
    ce_d   = 1'b0;
    if (mode_chg) begin
      rate_d = reload_val(pnl.mode);
    end else begin
      unique case (mode_q)
        MODE_SLOW, MODE_FAST: begin
          if (rate_q == '0) begin
            ce_d   = 1'b1;
            rate_d = reload_val(mode_q);
          end else begin
            rate_d = rate_q - 1'b1;
          end
        end
        MODE_STEP: ce_d = step_edge_q;
        MODE_HALT: ce_d = 1'b0;
      endcase
    end
  end

  // mode copy, rate counter, clock enable and heartbeat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_HALT;
      rate_q <= SLOW_LD;
      ce_q   <= 1'b0;
      led_q  <= 1'b0;
    end else begin
      mode_q <= pnl.mode;
      rate_q <= rate_d;
      ce_q   <= ce_d;
      led_q  <= led_q ^ ce_q;
    end
  end

  assign pnl.in_data = in_data_q;
  assign pnl.cpu_ce  = ce_q;
  assign pnl.run_led = led_q;

endmodule

// File: doc/td4_front_panel.md
# td4_front_panel

Front-panel conditioning stage directly upstream of the TD4 CPU core. Synchronizes and debounces the four raw active-low input buttons into clean active-high input-port data. Generates the single-cycle CPU clock-enable pulse in one of four modes: halt, slow free-run, fast free-run, or manual single-step from a dedicated step button. Everything runs on the board clock; the CPU core advances only on cycles where `cpu_ce` is high.

## Interface
Parameters:
- `DB_CYCLES`, 500000: consecutive stable cycles required to accept a new button level; ≥2.
- `SLOW_DIV`, 50000000: board cycles per `cpu_ce` pulse in slow mode; ≥2.
- `FAST_DIV`, 5000000: board cycles per `cpu_ce` pulse in fast mode; ≥2.

Ports:
- `clk`  in  1  board clock; all state on rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `btn`  in  4  raw input-port buttons, active-low, asynchronous to `clk`.
- `step_n`  in  1  raw single-step button, active-low, asynchronous.
- `mode`  in  2  run mode: 00 halt, 01 slow, 10 fast, 11 manual; treated as quasi-static.
- `in_data`  out  4  debounced button levels, active-high (1 = pressed); feeds the CPU input port.
- `cpu_ce`  out  1  one-cycle CPU clock-enable pulse.
- `run_led`  out  1  toggles on every `cpu_ce` pulse; heartbeat indicator.

## Operation
- **Input path.** Each of the 5 raw inputs (`btn[3:0]`, `step_n`) passes through a 2-flop synchronizer, then its own debouncer.
- **Debouncer.** Holds an accepted level and a counter.
  - Counter clears whenever the synchronized value equals the accepted level.
  - Otherwise it increments.
  - When it would reach `DB_CYCLES`, the accepted level flips and the counter clears.
  - A glitch shorter than `DB_CYCLES` cycles never changes the accepted level.
- **`in_data`.** `in_data[i]` = inverse of accepted `btn[i]`, registered.
- **Step edge.** Asserted when the accepted `step_n` goes 1→0 (press).
  - The release edge is ignored.
  - The edge detector runs in every mode. A press made outside manual mode is consumed, so switching into manual while the button is held produces no pulse.
- **Rate counter.** Down-counter, width `$clog2(max(SLOW_DIV,FAST_DIV))`.
  - Slow/fast: on reaching 0, assert `cpu_ce` the next cycle and reload `DIV-1`; otherwise decrement.
  - Halt/manual: counter held at `SLOW_DIV-1`, no rate pulses.
- **Mode change.** A registered copy of `mode` is compared each cycle. On any change, the counter reloads to the new mode's `DIV-1` and no pulse is emitted that cycle. Reload always wins over expiry.
- **Pulse sources.** Manual: `cpu_ce` = registered step edge. Halt: `cpu_ce` stays 0.
- **`run_led`.** Toggles on the cycle `cpu_ce` is 1.

## Timing
- **Reset values.**
  - Synchronizer flops and accepted levels = 1 (released).
  - Debounce counters = 0.
  - `in_data` = 0000, `cpu_ce` = 0, `run_led` = 0.
  - Registered mode = 00.
  - Rate counter = `SLOW_DIV-1`.
- **Reset mid-pulse.** Asserting `rst` while `cpu_ce` = 1 forces it to 0 immediately. Partial debounce counts are discarded.
- **Button latency.** A raw level change stable from edge k appears on `in_data` after edge k+`DB_CYCLES`+2, i.e. 2 synchronizer edges plus `DB_CYCLES` debounce edges.
- **Step latency.** A stable step press from edge k gives `cpu_ce` high for exactly one cycle after edge k+`DB_CYCLES`+3.
- **Free-run rate.** The first pulse comes `DIV` cycles after the mode-change reload. Pulses then repeat exactly every `DIV` cycles; `cpu_ce` is never high on two consecutive cycles.
- **Same-cycle events.** A mode change in the same cycle as a pending step edge or counter expiry suppresses that pulse.

## Structure
- **Shared package `td4_pkg`.** Holds:
  - the mode encoding constants `MODE_HALT`, `MODE_SLOW`, `MODE_FAST`, `MODE_STEP`;
  - the CPU data width (4), which sets the `in_data` width.
- **Sub-module `td4_debounce`.** Contains the synchronizer, debounce counter and accepted level, parameterized by `DB_CYCLES`. It is instantiated 5 times. The top level holds the edge detect, rate counter, mode register and LED toggle.

## Test plan
Bench parameters: `DB_CYCLES`=4, `SLOW_DIV`=10, `FAST_DIV`=3.
- **Reset.** Assert `rst` mid-run with `mode`=01 → `in_data`=0000, `cpu_ce`=0, `run_led`=0 immediately; first pulse 10 cycles after release.
- **Debounce.** Press `btn[2]` for 3 cycles → `in_data` stays 0000. Press and hold → `in_data`=0100 exactly 6 edges after the change. Release → returns to 0000 after 6 edges.
- **Fast mode.** `mode`=10 for 30 cycles → exactly 10 one-cycle `cpu_ce` pulses at spacing 3; `run_led` toggles 10 times.
- **Manual step.**
  - `mode`=11, one clean step press → one `cpu_ce` pulse 7 edges after the press.
  - Hold 50 cycles → no further pulses.
  - Bouncy press (1-cycle glitches) → still exactly one pulse.
- **Mode switching.**
  - Switch 01→10 one cycle before a slow expiry → no pulse on the switch cycle; next pulse 3 cycles later.
  - Switch to 00 → no pulses for 100 cycles.
- **Held step across mode change.** Step held while in 01, then switch to 11 → no pulse until release and a fresh press.
